// File: rtl/pipe_collision_detector.sv
// Pipe/fighter overlap detector: accumulates per-frame contact statistics
// and publishes frame-stable results at each vertical-sync falling edge.

module pipe_contact_track #(
    parameter logic [9:0] PIPE_X      = 10'd320,
    parameter logic [9:0] PIPE_Y      = 10'd432,
    parameter logic [9:0] PIPE_HALF_H = 10'd47,
    parameter logic [9:0] TOP_BAND    = 10'd4,
    parameter int         COUNT_W     = 12
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               fb,
    input  logic               overlap,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic               done,
    output logic               hit,
    output logic [1:0]         side,
    output logic [COUNT_W-1:0] cnt
);

    localparam logic [0:0] WAIT_SYNC = 1'b0;
    localparam logic [0:0] ACCUM     = 1'b1;

    localparam logic [1:0] SIDE_NONE  = 2'b00;
    localparam logic [1:0] SIDE_TOP   = 2'b01;
    localparam logic [1:0] SIDE_LEFT  = 2'b10;
    localparam logic [1:0] SIDE_RIGHT = 2'b11;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [9:0] TOP_LIMIT = PIPE_Y - PIPE_HALF_H + TOP_BAND;

    logic [0:0]         state_q, state_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               first_q, first_d;
    logic [1:0]         cap_q, cap_d;
    logic               hit_q, hit_d;
    logic [1:0]         side_q, side_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [1:0]         pix_side;
    logic [COUNT_W-1:0] acc_nx;
    logic [1:0]         cap_nx;
    logic               first_nx;

    always_comb begin
        if (pix_y <= TOP_LIMIT) begin
            pix_side = SIDE_TOP;
        end else if (pix_x < PIPE_X) begin
            pix_side = SIDE_LEFT;
        end else begin
            pix_side = SIDE_RIGHT;
        end
    end

    // Next accumulator view including this cycle's pixel, so an overlap
    // on the sync edge itself still lands in the published frame.
    always_comb begin
        acc_nx   = acc_q;
        cap_nx   = cap_q;
        first_nx = first_q;
        if (overlap) begin
            if (acc_q != CNT_MAX) begin
                acc_nx = acc_q + COUNT_W'(1);
            end
            if (!first_q) begin
                cap_nx   = pix_side;
                first_nx = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_nx;
        first_d = first_nx;
        cap_d   = cap_nx;
        hit_d   = hit_q;
        side_d  = side_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (fb) begin
            acc_d   = '0;
            first_d = 1'b0;
            cap_d   = SIDE_NONE;
            case (state_q)
                WAIT_SYNC: begin
                    state_d = ACCUM;
                end
                ACCUM: begin
                    cnt_d  = acc_nx;
                    hit_d  = (acc_nx != '0);
                    side_d = (acc_nx != '0) ? cap_nx : SIDE_NONE;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= WAIT_SYNC;
            acc_q   <= '0;
            first_q <= 1'b0;
            cap_q   <= SIDE_NONE;
            hit_q   <= 1'b0;
            side_q  <= SIDE_NONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            cap_q   <= cap_d;
            hit_q   <= hit_d;
            side_q  <= side_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign hit  = hit_q;
    assign side = side_q;
    assign cnt  = cnt_q;

endmodule

module pipe_collision_detector #(
    parameter logic [9:0] PIPE_X      = 10'd320,
    parameter logic [9:0] PIPE_Y      = 10'd432,
    parameter logic [9:0] PIPE_HALF_H = 10'd47,
    parameter logic [9:0] TOP_BAND    = 10'd4,
    parameter int         COUNT_W     = 12
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               VGA_VS,
    input  logic               is_pipe,
    input  logic               is_fighter0,
    input  logic               is_fighter1,
    output logic               frame_done,
    output logic               hit0,
    output logic               hit1,
    output logic [1:0]         side0,
    output logic [1:0]         side1,
    output logic [COUNT_W-1:0] ovl_cnt0,
    output logic [COUNT_W-1:0] ovl_cnt1
);

    logic vs_prev_q, vs_prev_d;
    logic fb;
    logic visible;
    logic ovl0, ovl1;
    logic done0, done1;

    always_comb begin
        vs_prev_d = VGA_VS;
        fb        = vs_prev_q & ~VGA_VS;
        visible   = (DrawX < 10'd640) & (DrawY < 10'd480);
        ovl0      = is_pipe & is_fighter0 & visible;
        ovl1      = is_pipe & is_fighter1 & visible;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vs_prev_q <= 1'b1;
        end else begin
            vs_prev_q <= vs_prev_d;
        end
    end

    pipe_contact_track #(
        .PIPE_X(PIPE_X), .PIPE_Y(PIPE_Y), .PIPE_HALF_H(PIPE_HALF_H),
        .TOP_BAND(TOP_BAND), .COUNT_W(COUNT_W)
    ) u_trk0 (
        .Clk(Clk), .Reset(Reset), .fb(fb), .overlap(ovl0),
        .pix_x(DrawX), .pix_y(DrawY), .done(done0),
        .hit(hit0), .side(side0), .cnt(ovl_cnt0)
    );

    pipe_contact_track #(
        .PIPE_X(PIPE_X), .PIPE_Y(PIPE_Y), .PIPE_HALF_H(PIPE_HALF_H),
        .TOP_BAND(TOP_BAND), .COUNT_W(COUNT_W)
    ) u_trk1 (
        .Clk(Clk), .Reset(Reset), .fb(fb), .overlap(ovl1),
        .pix_x(DrawX), .pix_y(DrawY), .done(done1),
        .hit(hit1), .side(side1), .cnt(ovl_cnt1)
    );

    // Both trackers share the sync edge, so their publish pulses coincide.
    assign frame_done = done0 | done1;

endmodule

// File: tb/tb_pipe_collision_detector.sv
// Randomized and directed bench for pipe_collision_detector against a
// frame-level reference model.

module tb_pipe_collision_detector;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        VGA_VS = 1'b1;
    logic        is_pipe = 1'b0;
    logic        is_fighter0 = 1'b0;
    logic        is_fighter1 = 1'b0;
    logic        frame_done;
    logic        hit0, hit1;
    logic [1:0]  side0, side1;
    logic [11:0] ovl_cnt0, ovl_cnt1;

    pipe_collision_detector dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .VGA_VS(VGA_VS), .is_pipe(is_pipe),
        .is_fighter0(is_fighter0), .is_fighter1(is_fighter1),
        .frame_done(frame_done), .hit0(hit0), .hit1(hit1),
        .side0(side0), .side1(side1),
        .ovl_cnt0(ovl_cnt0), .ovl_cnt1(ovl_cnt1)
    );

    always #5 Clk = ~Clk;

    int n_err = 0;
    int n_chk = 0;

    // reference model: per-frame bookkeeping in plain integers
    bit m_vsp;
    bit m_started;
    int m_acc[2];
    bit m_seen[2];
    int m_side[2];
    int e_cnt[2];
    bit e_hit[2];
    int e_side[2];
    bit e_fd;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vsp = 1'b1;
        m_started = 1'b0;
        e_fd = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_acc[n] = 0; m_seen[n] = 0; m_side[n] = 0;
            e_cnt[n] = 0; e_hit[n] = 0; e_side[n] = 0;
        end
    endtask

    task automatic model_step(input int x, input int y, input bit vs,
                              input bit p, input bit f0, input bit f1);
        bit fb;
        bit ov;
        fb = m_vsp && !vs;
        m_vsp = vs;
        for (int n = 0; n < 2; n++) begin
            ov = p && (n == 0 ? f0 : f1) && x < 640 && y < 480;
            if (ov) begin
                m_acc[n] = (m_acc[n] + 1 > 4095) ? 4095 : m_acc[n] + 1;
                if (!m_seen[n]) begin
                    m_seen[n] = 1;
                    if (y <= 385 + 4) m_side[n] = 1;
                    else if (x < 320) m_side[n] = 2;
                    else m_side[n] = 3;
                end
            end
        end
        e_fd = 1'b0;
        if (fb) begin
            for (int n = 0; n < 2; n++) begin
                if (m_started) begin
                    e_cnt[n] = m_acc[n];
                    e_hit[n] = (m_acc[n] != 0);
                    e_side[n] = e_hit[n] ? m_side[n] : 0;
                end
                m_acc[n] = 0; m_seen[n] = 0; m_side[n] = 0;
            end
            if (m_started) e_fd = 1'b1;
            m_started = 1'b1;
        end
    endtask

    task automatic check_outs();
        chk("frame_done", int'(frame_done), int'(e_fd));
        chk("hit0", int'(hit0), int'(e_hit[0]));
        chk("hit1", int'(hit1), int'(e_hit[1]));
        chk("side0", int'(side0), e_side[0]);
        chk("side1", int'(side1), e_side[1]);
        chk("ovl_cnt0", int'(ovl_cnt0), e_cnt[0]);
        chk("ovl_cnt1", int'(ovl_cnt1), e_cnt[1]);
    endtask

    // called at a falling edge: drive, model, advance one cycle, compare
    task automatic step(input int x, input int y, input bit vs,
                        input bit p, input bit f0, input bit f1);
        DrawX = x[9:0];
        DrawY = y[9:0];
        VGA_VS = vs;
        is_pipe = p;
        is_fighter0 = f0;
        is_fighter1 = f1;
        model_step(x, y, vs, p, f0, f1);
        @(negedge Clk);
        check_outs();
    endtask

    task automatic vsync();
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        model_reset();
        repeat (3) @(negedge Clk);
        check_outs();
        Reset = 1'b1;

        // two sync edges with no fighters: only the second publishes
        repeat (5) step(10, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_fb_fd", int'(frame_done), 0);
        repeat (5) step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("second_fb_fd", int'(frame_done), 1);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fd_one_cycle", int'(frame_done), 0);

        // 10x5 block at the pipe top edge
        for (int y = 385; y < 390; y++)
            for (int x = 300; x < 310; x++)
                step(x, y, 1'b1, 1'b1, 1'b1, 1'b0);
        vsync();
        chk("blk_hit0", int'(hit0), 1);
        chk("blk_cnt0", int'(ovl_cnt0), 50);
        chk("blk_side0", int'(side0), 1);
        chk("blk_hit1", int'(hit1), 0);

        // first contact decides the side
        step(297, 400, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(310, 400, 1'b1, 1'b0, 1'b0, 1'b1);
        step(330, 400, 1'b1, 1'b1, 1'b0, 1'b1);
        vsync();
        chk("left_side1", int'(side1), 2);
        chk("left_cnt1", int'(ovl_cnt1), 2);
        step(330, 420, 1'b1, 1'b1, 1'b0, 1'b1);
        vsync();
        chk("right_side1", int'(side1), 3);

        // saturation then a clean frame
        repeat (5000)
            step($urandom_range(0, 639), $urandom_range(0, 479),
                 1'b1, 1'b1, 1'b1, 1'b0);
        vsync();
        chk("sat_cnt0", int'(ovl_cnt0), 4095);
        vsync();
        chk("clean_cnt0", int'(ovl_cnt0), 0);
        chk("clean_hit0", int'(hit0), 0);

        // overlap on the sync-edge cycle itself
        repeat (7) step(350, 450, 1'b1, 1'b1, 1'b1, 1'b0);
        step(351, 450, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fbpix_cnt0", int'(ovl_cnt0), 8);
        chk("fbpix_side0", int'(side0), 3);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(700, 450, 1'b1, 1'b1, 1'b1, 1'b1);
        step(100, 500, 1'b1, 1'b1, 1'b1, 1'b1);
        vsync();
        chk("offscr_cnt0", int'(ovl_cnt0), 0);
        chk("offscr_hit1", int'(hit1), 0);

        // VS held low: one publish only
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            pulses += int'(frame_done);
        end
        chk("vs_low_pulses", pulses, 1);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // mid-frame asynchronous reset
        repeat (6) step(200, 450, 1'b1, 1'b1, 1'b0, 1'b1);
        vsync();
        chk("pre_rst_cnt1", int'(ovl_cnt1), 6);
        repeat (20) step(200, 450, 1'b1, 1'b1, 1'b1, 1'b0);
        Reset = 1'b0;
        #1;
        chk("rst_hit1", int'(hit1), 0);
        chk("rst_cnt1", int'(ovl_cnt1), 0);
        chk("rst_side1", int'(side1), 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) step(200, 450, 1'b1, 1'b1, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_nofd", int'(frame_done), 0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(310, 300, 1'b1, 1'b1, 1'b1, 1'b0);
        vsync();
        chk("post_rst_cnt0", int'(ovl_cnt0), 4);
        chk("post_rst_side0", int'(side0), 1);

        // random frames
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(20, 200);
            for (int i = 0; i < len + 4; i++) begin
                int x, y;
                x = ($urandom_range(0, 3) != 0) ? $urandom_range(270, 370)
                                                : $urandom_range(0, 1023);
                y = $urandom_range(360, 495);
                step(x, y, (i < len) ? 1'b1 : 1'b0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_collision_detector.md
Name: pipe_collision_detector

Overview:
- Sits downstream of the pipe object; consumes its per-pixel is_pipe flag together with both fighters' per-pixel flags during the raster scan.
- Accumulates pipe/fighter overlap over each frame and classifies the contact side from the first overlapping pixel.
- Publishes registered, frame-stable collision results at each vertical-sync boundary for the fighter motion logic.

Parameters:
PIPE_X, 10'd320, pipe centre X (pixels)
PIPE_Y, 10'd432, pipe centre Y
PIPE_HALF_H, 10'd47, pipe half-height; pipe top edge = PIPE_Y - PIPE_HALF_H = 385
TOP_BAND, 10'd4, rows below the pipe top edge classified as TOP contact
COUNT_W, 12, overlap pixel counter width

Ports:
Clk  input  1  pixel clock
Reset  input  1  asynchronous, active-low reset
DrawX  input  10  current pixel X
DrawY  input  10  current pixel Y
VGA_VS  input  1  vertical sync, active-low
is_pipe  input  1  pixel lies on pipe
is_fighter0  input  1  pixel lies on fighter 0
is_fighter1  input  1  pixel lies on fighter 1
frame_done  output  1  one-cycle pulse when new results are published
hit0, hit1  output  1  fighter n overlapped the pipe last frame
side0, side1  output  2  contact side: 00 NONE, 01 TOP, 10 LEFT, 11 RIGHT
ovl_cnt0, ovl_cnt1  output  COUNT_W  overlapping pixel count last frame, saturating

Behaviour:
- Reset low (asynchronous):
  - All outputs 0 (sides NONE); accumulators cleared; first-hit flags cleared.
  - vs_prev register set to 1.
- Visible pixel: DrawX < 640 and DrawY < 480. Overlap_n = is_pipe & is_fighter_n & visible.
- Frame boundary (fb): vs_prev == 1 and VGA_VS == 0. vs_prev <= VGA_VS every cycle.
- Per fighter n, state ACCUM every cycle:
  - Overlap_n: acc_cnt_n += 1, saturating at 2^COUNT_W - 1 (no wrap).
  - Overlap_n with first_n == 0: capture side and set first_n.
    - TOP if DrawY <= 385 + TOP_BAND.
    - Otherwise LEFT if DrawX < PIPE_X, RIGHT if DrawX >= PIPE_X.
    - Later overlaps in the same frame never change the captured side.
- Publish on the fb cycle, registered, visible the next cycle:
  - ovl_cnt_n <= acc value including any overlap on the fb cycle itself.
  - hit_n <= (that value != 0).
  - side_n <= captured side, or NONE if no hit.
  - frame_done = 1 for exactly that one following cycle.
  - Same edge: acc_cnt_n <= 0, first_n <= 0.
- Two-state FSM per detector: WAIT_SYNC (after reset) -> ACCUM on first fb.
  - The first fb after reset only clears accumulators; no publish, no frame_done, outputs stay 0 (the partial first frame is discarded).
  - All later fb cycles publish.
- Outputs hold between publishes; mid-frame changes never reach outputs.
- VGA_VS held low: one fb only, no repeated publish.
- Both fighters are fully independent; simultaneous overlaps on the same pixel count for both.
- Overlap at DrawX >= 640 or DrawY >= 480 is ignored.
- Reset asserted mid-frame: everything returns to reset values, FSM returns to WAIT_SYNC.

Test Plan:
- Reset, two VS falling edges, no fighter pixels -> first edge no frame_done; second edge frame_done pulse 1 cycle; hit0 = hit1 = 0, sides 00, counts 0.
- Frame with is_pipe & is_fighter0 over a 10x5 block starting at (300,385) -> after fb: hit0 = 1, ovl_cnt0 = 50, side0 = 01 (TOP); fighter1 outputs 0.
- Fighter1 overlap first at (297,400), later at (330,400) -> side1 = 10 (LEFT) despite the later right-side pixel; overlap first at (330,420) in the next frame -> side1 = 11.
- Force overlap for 5000 visible cycles with COUNT_W = 12 -> ovl_cnt0 = 4095 (saturated); following clean frame -> ovl_cnt0 = 0, hit0 = 0.
- Overlap asserted on the fb cycle with acc = 7 -> published ovl_cnt = 8; next frame count starts from 0. Overlap at DrawX = 700 -> not counted.
- Reset pulsed low mid-frame after 20 overlap pixels -> outputs 0 immediately (asynchronous); next fb no publish; the fb after that publishes only post-reset-frame data.
